// File: rtl/lc3x_mult_div_unit.sv
// lc3x_mult_div_unit: iterative signed shift-add multiply / restoring divide with done pulse
module lc3x_mult_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op, r_neg_q, r_neg_r, r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0]   r_opnd, r_result, r_rem;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_lo, w_hi, w_res, w_rem;
  logic [WIDTH:0]     w_sum, w_trial;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_b_zero;
  // The accumulator holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    w_mag_a   = a[WIDTH-1] ? -a : a;
    w_mag_b   = b[WIDTH-1] ? -b : b;
    w_b_zero  = b == '0;
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    w_acc_nxt = !r_op ? {w_sum, r_acc[WIDTH-1:1]} :
                w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0} :
                {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    w_lo      = w_acc_nxt[WIDTH-1:0];
    w_hi      = w_acc_nxt[2*WIDTH-1:WIDTH];
    w_res     = r_neg_q ? -w_lo : w_lo;
    w_rem     = !r_op ? '0 : r_neg_r ? -w_hi : w_hi;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_opnd     <= '0;
      r_result   <= '0;
      r_rem      <= '0;
      r_acc      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start && !flush) begin
          r_op       <= op;
          r_neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
          r_neg_r    <= a[WIDTH-1];
          r_cnt      <= CNT_W'(WIDTH);
          r_opnd     <= op ? w_mag_b : w_mag_a;
          r_acc      <= {{WIDTH{1'b0}}, op ? w_mag_a : w_mag_b};
          r_div_zero <= op && w_b_zero;
          if (op && w_b_zero) begin
            r_result <= '1;
            r_rem    <= a;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: if (flush) begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_result <= w_res;
            r_rem    <= w_rem;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy      = r_busy;
  assign done      = r_done && !flush;
  assign result    = r_result;
  assign remainder = r_rem;
  assign div_zero  = r_div_zero;
endmodule

// File: tb/tb_lc3x_mult_div_unit.sv
// tb_lc3x_mult_div_unit: directed checks of cycle timing and signed results of lc3x_mult_div_unit
module tb_lc3x_mult_div_unit;
  logic        clk, reset_n, start, op, flush;
  logic [15:0] a, b;
  logic        busy, done, div_zero;
  logic [15:0] result, remainder;
  int passed = 0, total = 0, errors = 0;
  lc3x_mult_div_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result), .remainder(remainder), .div_zero(div_zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; op = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
  endtask
  task automatic track(input string tag, input int ecyc, input logic [15:0] er,
                       input logic [15:0] erem, input logic edz);
    for (int c = 1; c <= ecyc; c++) begin
      @(negedge clk);
      chk({tag, " busy"}, 16'(busy), 16'(c < ecyc));
      chk({tag, " done"}, 16'(done), 16'(c == ecyc));
    end
    chk({tag, " result"}, result, er);
    chk({tag, " remainder"}, remainder, erem);
    chk({tag, " div_zero"}, 16'(div_zero), 16'(edz));
  endtask
  task automatic run_op(input string tag, input logic o, input logic [15:0] x, input logic [15:0] y,
                        input int ecyc, input logic [15:0] er, input logic [15:0] erem, input logic edz);
    start_op(o, x, y);
    track(tag, ecyc, er, erem, edz);
  endtask
  initial begin
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 1'b0; a = '0; b = '0;
    #2;
    chk("rst busy", 16'(busy), 16'h0);
    chk("rst done", 16'(done), 16'h0);
    chk("rst result", result, 16'h0);
    chk("rst remainder", remainder, 16'h0);
    chk("rst div_zero", 16'(div_zero), 16'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    run_op("mul 7*-3", 1'b0, 16'h0007, 16'hFFFD, 17, 16'hFFEB, 16'h0000, 1'b0);
    run_op("div -100/7", 1'b1, 16'hFF9C, 16'h0007, 17, 16'hFFF2, 16'hFFFE, 1'b0);
    run_op("div 100/-7", 1'b1, 16'h0064, 16'hFFF9, 17, 16'hFFF2, 16'h0002, 1'b0);
    run_op("div 5/0", 1'b1, 16'h0005, 16'h0000, 1, 16'hFFFF, 16'h0005, 1'b1);
    run_op("mul 2*3", 1'b0, 16'h0002, 16'h0003, 17, 16'h0006, 16'h0000, 1'b0);
    run_op("div min/-1", 1'b1, 16'h8000, 16'hFFFF, 17, 16'h8000, 16'h0000, 1'b0);
    run_op("mul min*-1", 1'b0, 16'h8000, 16'hFFFF, 17, 16'h8000, 16'h0000, 1'b0);
    run_op("mul max*max", 1'b0, 16'h7FFF, 16'h7FFF, 17, 16'h0001, 16'h0000, 1'b0);
    // Starts while busy (cycle 3) and in DONE (cycle 17) must be ignored
    start_op(1'b0, 16'h000A, 16'h0014);
    for (int c = 1; c <= 17; c++) begin
      start = (c == 3 || c == 17); op = 1'b1; a = 16'h0063; b = (c == 3) ? 16'h0000 : 16'h0003;
      @(negedge clk);
      chk("ign busy", 16'(busy), 16'(c < 17));
      chk("ign done", 16'(done), 16'(c == 17));
      @(posedge clk);
      #1;
    end
    chk("ign result", result, 16'h00C8);
    chk("ign remainder", remainder, 16'h0000);
    start = 1'b1; op = 1'b0; a = 16'h0004; b = 16'h0005;
    @(negedge clk);
    chk("c18 done", 16'(done), 16'h0);
    chk("c18 busy", 16'(busy), 16'h0);
    @(posedge clk);
    #1 start = 1'b0;
    track("c18 mul 4*5", 17, 16'h0014, 16'h0000, 1'b0);
    // Flush in IDLE drops a coincident start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 1'b0; a = 16'h0003; b = 16'h0003;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle flush busy", 16'(busy), 16'h0);
    chk("idle flush done", 16'(done), 16'h0);
    start_op(1'b0, 16'h0009, 16'h0009);
    for (int c = 1; c <= 22; c++) begin
      flush = (c == 5);
      @(negedge clk);
      chk("flush busy", 16'(busy), 16'(c <= 5));
      chk("flush done", 16'(done), 16'h0);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    chk("flush result", result, 16'h0014);
    start_op(1'b0, 16'h0003, 16'h0003);
    for (int c = 1; c < 8; c++) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    chk("mid rst busy", 16'(busy), 16'h0);
    chk("mid rst done", 16'(done), 16'h0);
    chk("mid rst result", result, 16'h0);
    chk("mid rst remainder", remainder, 16'h0);
    chk("mid rst div_zero", 16'(div_zero), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("post rst mul -1*-1", 1'b0, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'h0000, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
